// File: rtl/pipe_reg_chain_pkg.sv
// Shared types and helpers for the generic pipeline register chain.
package pipe_reg_chain_pkg;

    // What a single stage does on the next clock edge.
    typedef enum logic [1:0] {
        STAGE_ADVANCE = 2'd0,
        STAGE_BUBBLE  = 2'd1,
        STAGE_FLUSH   = 2'd2,
        STAGE_HOLD    = 2'd3
    } stage_op_e;

    // Valid bit loaded by a bubble or a flush.
    localparam logic BUBBLE_VALID = 1'b0;

    // Priority decode for one stage: hold beats flush, flush beats bubble.
    // hold_up is the hold of the stage feeding this one (0 for stage 0).
    function automatic stage_op_e decode_stage(input logic hold,
                                               input logic hold_up,
                                               input logic flush);
        stage_op_e op;
        if (hold) begin
            op = STAGE_HOLD;
        end else if (flush) begin
            op = STAGE_FLUSH;
        end else if (hold_up) begin
            op = STAGE_BUBBLE;
        end else begin
            op = STAGE_ADVANCE;
        end
        return op;
    endfunction

endpackage

// File: rtl/pipe_reg_chain_stage.sv
// One register stage of the pipeline chain: valid bit plus payload.
module pipe_stage_reg
    import pipe_reg_chain_pkg::*;
#(
    parameter int WIDTH         = 32,
    parameter int ZERO_ON_FLUSH = 1
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             hold,
    input  logic             load_bubble,
    input  logic             valid_in,
    input  logic [WIDTH-1:0] data_in,
    output logic             valid_out,
    output logic [WIDTH-1:0] data_out
);

    logic             valid_q;
    logic [WIDTH-1:0] data_q;

    // Stage register: reset clears, hold keeps, bubble invalidates, otherwise load upstream.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else if (!hold) begin
            if (load_bubble) begin
                valid_q <= BUBBLE_VALID;
                if (ZERO_ON_FLUSH != 0) begin
                    data_q <= '0;
                end
            end else begin
                valid_q <= valid_in;
                data_q  <= data_in;
            end
        end
    end

    assign valid_out = valid_q;
    assign data_out  = data_q;

endmodule

// File: rtl/pipe_reg_chain.sv
// Generic chain of DEPTH pipeline registers with stall, flush, freeze and event counters.
module pipe_reg_chain
    import pipe_reg_chain_pkg::*;
#(
    parameter int WIDTH         = 32,
    parameter int DEPTH         = 4,
    parameter int ZERO_ON_FLUSH = 1,
    parameter int CNT_W         = 16
) (
    input  logic                   clk_i,
    input  logic                   rst_n_i,
    input  logic                   freeze_i,
    input  logic [DEPTH-1:0]       stall_i,
    input  logic [DEPTH-1:0]       flush_i,
    input  logic                   valid_i,
    input  logic [WIDTH-1:0]       data_i,
    output logic                   ready_o,
    output logic [DEPTH-1:0]       valid_o,
    output logic [DEPTH*WIDTH-1:0] data_o,
    output logic [CNT_W-1:0]       bubble_cnt_o,
    output logic [CNT_W-1:0]       flush_cnt_o
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [DEPTH-1:0] hold;
    logic [DEPTH-1:0] hold_up;
    logic [DEPTH-1:0] stage_hold;
    logic [DEPTH-1:0] load_bubble;
    logic             bubble_event;
    logic             flush_event;
    stage_op_e        stage_op [DEPTH];

    logic             stage_valid [DEPTH];
    logic [WIDTH-1:0] stage_data  [DEPTH];

    logic [CNT_W-1:0] bubble_cnt_q;
    logic [CNT_W-1:0] flush_cnt_q;

    // A stall anywhere downstream (or a freeze) backs up every stage above it.
    always_comb begin
        logic acc;
        acc  = freeze_i;
        hold = '0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            acc     = acc | stall_i[k];
            hold[k] = acc;
        end
    end

    assign hold_up = hold << 1;

    // Decode each stage's action and note whether any bubble or flush happens this cycle.
    always_comb begin
        stage_hold   = '0;
        load_bubble  = '0;
        bubble_event = 1'b0;
        flush_event  = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            stage_op[k]    = decode_stage(hold[k], hold_up[k], flush_i[k]);
            stage_hold[k]  = (stage_op[k] == STAGE_HOLD);
            load_bubble[k] = (stage_op[k] == STAGE_FLUSH) || (stage_op[k] == STAGE_BUBBLE);
            if (stage_op[k] == STAGE_BUBBLE) begin
                bubble_event = 1'b1;
            end
            if (stage_op[k] == STAGE_FLUSH) begin
                flush_event = 1'b1;
            end
        end
    end

    genvar g;
    generate
        for (g = 0; g < DEPTH; g++) begin : g_stage
            logic             in_valid;
            logic [WIDTH-1:0] in_data;

            if (g == 0) begin : g_head
                assign in_valid = valid_i;
                assign in_data  = data_i;
            end else begin : g_body
                assign in_valid = stage_valid[g-1];
                assign in_data  = stage_data[g-1];
            end

            pipe_stage_reg #(
                .WIDTH        (WIDTH),
                .ZERO_ON_FLUSH(ZERO_ON_FLUSH)
            ) u_stage (
                .clk_i      (clk_i),
                .rst_n_i    (rst_n_i),
                .hold       (stage_hold[g]),
                .load_bubble(load_bubble[g]),
                .valid_in   (in_valid),
                .data_in    (in_data),
                .valid_out  (stage_valid[g]),
                .data_out   (stage_data[g])
            );

            assign valid_o[g]                = stage_valid[g];
            assign data_o[g*WIDTH +: WIDTH]  = stage_data[g];
        end
    endgenerate

    // Saturating per-cycle event counters; a freeze holds every stage so nothing counts.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            bubble_cnt_q <= '0;
            flush_cnt_q  <= '0;
        end else begin
            if (bubble_event && (bubble_cnt_q != CNT_MAX)) begin
                bubble_cnt_q <= bubble_cnt_q + 1'b1;
            end
            if (flush_event && (flush_cnt_q != CNT_MAX)) begin
                flush_cnt_q <= flush_cnt_q + 1'b1;
            end
        end
    end

    assign ready_o      = ~hold[0];
    assign bubble_cnt_o = bubble_cnt_q;
    assign flush_cnt_o  = flush_cnt_q;

endmodule

// File: tb/tb_pipe_reg_chain.sv
// Testbench for pipe_reg_chain: scoreboarded stream plus directed stall/flush/freeze cases.
module tb_pipe_reg_chain;

    logic         clk;
    logic         rst_n;
    logic         freeze;
    logic [3:0]   stall;
    logic [3:0]   flush;
    logic         valid_in;
    logic [31:0]  data_in;
    logic         ready;
    logic [3:0]   valid_out;
    logic [127:0] data_out;
    logic [15:0]  bubble_cnt;
    logic [15:0]  flush_cnt;

    logic         rst_n_b;
    logic         freeze_b;
    logic [2:0]   stall_b;
    logic [2:0]   flush_b;
    logic         valid_in_b;
    logic [15:0]  data_in_b;
    logic         ready_b;
    logic [2:0]   valid_out_b;
    logic [47:0]  data_out_b;
    logic [1:0]   bubble_cnt_b;
    logic [1:0]   flush_cnt_b;

    int           checks;
    int           errors;
    logic [31:0]  sb [$];

    pipe_reg_chain #(.WIDTH(32), .DEPTH(4), .ZERO_ON_FLUSH(1), .CNT_W(16)) dut (
        .clk_i       (clk),
        .rst_n_i     (rst_n),
        .freeze_i    (freeze),
        .stall_i     (stall),
        .flush_i     (flush),
        .valid_i     (valid_in),
        .data_i      (data_in),
        .ready_o     (ready),
        .valid_o     (valid_out),
        .data_o      (data_out),
        .bubble_cnt_o(bubble_cnt),
        .flush_cnt_o (flush_cnt)
    );

    pipe_reg_chain #(.WIDTH(16), .DEPTH(3), .ZERO_ON_FLUSH(0), .CNT_W(2)) dut_b (
        .clk_i       (clk),
        .rst_n_i     (rst_n_b),
        .freeze_i    (freeze_b),
        .stall_i     (stall_b),
        .flush_i     (flush_b),
        .valid_i     (valid_in_b),
        .data_i      (data_in_b),
        .ready_o     (ready_b),
        .valid_o     (valid_out_b),
        .data_o      (data_out_b),
        .bubble_cnt_o(bubble_cnt_b),
        .flush_cnt_o (flush_cnt_b)
    );

    // Free-running clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [127:0] actual, input logic [127:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    // One clock: sample at negedge, let the edge happen, then update the scoreboard.
    task automatic tick();
        logic        accept;
        logic        leave;
        logic        killed;
        logic        stage3_hold;
        logic [31:0] leave_data;
        logic [31:0] exp;
        @(negedge clk);
        stage3_hold = freeze | stall[3];
        accept      = rst_n && valid_in && ready && !flush[0];
        leave       = rst_n && valid_out[3] && !stage3_hold && !flush[3];
        killed      = rst_n && valid_out[3] && !stage3_hold && flush[3];
        leave_data  = data_out[127:96];
        @(posedge clk);
        #1;
        if (!rst_n) begin
            sb.delete();
        end else begin
            if (leave || killed) begin
                if (sb.size() == 0) begin
                    checkOutput("sb_underflow", 128'(leave_data), 128'hDEAD);
                end else begin
                    exp = sb.pop_front();
                    if (leave) checkOutput("sb_out", 128'(leave_data), 128'(exp));
                end
            end
            if (accept) sb.push_back(data_in);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [31:0] d);
        valid_in = v;
        data_in  = d;
        tick();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n = 1'b0; freeze = 1'b0; stall = '0; flush = '0; valid_in = 1'b0; data_in = '0;
        rst_n_b = 1'b0; freeze_b = 1'b0; stall_b = '0; flush_b = '0; valid_in_b = 1'b0; data_in_b = '0;

        // Reset state
        tick();
        tick();
        checkOutput("rst_valid", 128'(valid_out), 128'h0);
        checkOutput("rst_data", data_out, 128'h0);
        checkOutput("rst_bcnt", 128'(bubble_cnt), 128'h0);
        checkOutput("rst_fcnt", 128'(flush_cnt), 128'h0);
        checkOutput("rst_ready", 128'(ready), 128'h1);
        rst_n = 1'b1;

        // Fill the chain with A0..A3
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 32'hA0 + 32'(i));
        checkOutput("fill_valid", 128'(valid_out), 128'hF);
        checkOutput("fill_data", data_out, {32'hA0, 32'hA1, 32'hA2, 32'hA3});

        // Stall stage 1 for two cycles: stage 2 collects bubbles
        stall = 4'b0010;
        valid_in = 1'b1;
        data_in = 32'hA4;
        #1;
        checkOutput("stall_ready", 128'(ready), 128'h0);
        tick();
        tick();
        checkOutput("stall_v2", 128'(valid_out[2]), 128'h0);
        checkOutput("stall_d2", 128'(data_out[95:64]), 128'h0);
        checkOutput("stall_hold01", 128'(data_out[63:0]), {64'h0, 32'hA2, 32'hA3});
        checkOutput("stall_bcnt", 128'(bubble_cnt), 128'h2);
        stall = 4'b0000;
        for (int i = 4; i < 8; i++) applyStimulus(1'b1, 32'hA0 + 32'(i));
        for (int i = 0; i < 6; i++) applyStimulus(1'b0, 32'h0);
        checkOutput("sb_drained", 128'(sb.size()), 128'h0);

        // Flush under stall is dropped, then honoured alone
        applyStimulus(1'b1, 32'hB0);
        applyStimulus(1'b1, 32'hB1);
        valid_in = 1'b0;
        stall = 4'b0010;
        flush = 4'b0010;
        tick();
        checkOutput("sflush_v1", 128'(valid_out[1]), 128'h1);
        checkOutput("sflush_d1", 128'(data_out[63:32]), 128'hB0);
        checkOutput("sflush_fcnt", 128'(flush_cnt), 128'h0);
        checkOutput("sflush_bcnt", 128'(bubble_cnt), 128'h3);
        stall = 4'b0000;
        tick();
        void'(sb.pop_back());
        flush = 4'b0000;
        checkOutput("flush_v1", 128'(valid_out[1]), 128'h0);
        checkOutput("flush_d1", 128'(data_out[63:32]), 128'h0);
        checkOutput("flush_s2", 128'(data_out[95:64]), 128'hB0);
        checkOutput("flush_fcnt", 128'(flush_cnt), 128'h1);

        // Stall on the last stage holds everything without a bubble
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 32'hC0 + 32'(i));
        stall = 4'b1000;
        valid_in = 1'b1;
        data_in = 32'hC4;
        #1;
        checkOutput("last_ready", 128'(ready), 128'h0);
        tick();
        checkOutput("last_data", data_out, {32'hC0, 32'hC1, 32'hC2, 32'hC3});
        checkOutput("last_bcnt", 128'(bubble_cnt), 128'h3);
        stall = 4'b0000;

        // Freeze ignores flush and input
        freeze = 1'b1;
        flush = 4'b1111;
        for (int i = 0; i < 3; i++) tick();
        checkOutput("frz_valid", 128'(valid_out), 128'hF);
        checkOutput("frz_data", data_out, {32'hC0, 32'hC1, 32'hC2, 32'hC3});
        checkOutput("frz_bcnt", 128'(bubble_cnt), 128'h3);
        checkOutput("frz_fcnt", 128'(flush_cnt), 128'h1);
        freeze = 1'b0;
        flush = 4'b0000;
        tick();
        checkOutput("unfrz_data", data_out, {32'hC1, 32'hC2, 32'hC3, 32'hC4});

        // Mid-stream reset
        rst_n = 1'b0;
        applyStimulus(1'b1, 32'hC5);
        checkOutput("mrst_valid", 128'(valid_out), 128'h0);
        checkOutput("mrst_data", data_out, 128'h0);
        checkOutput("mrst_bcnt", 128'(bubble_cnt), 128'h0);
        checkOutput("mrst_fcnt", 128'(flush_cnt), 128'h0);
        rst_n = 1'b1;
        valid_in = 1'b0;

        // Payload-retaining instance with a 2-bit saturating counter
        tick();
        checkOutput("b_rst_valid", 128'(valid_out_b), 128'h0);
        checkOutput("b_rst_data", 128'(data_out_b), 128'h0);
        rst_n_b = 1'b1;
        valid_in_b = 1'b1;
        data_in_b = 16'h1234; tick();
        data_in_b = 16'hAAAA; tick();
        data_in_b = 16'hBBBB; tick();
        valid_in_b = 1'b0;
        checkOutput("b_fill", 128'(data_out_b), {16'h1234, 16'hAAAA, 16'hBBBB});
        flush_b = 3'b100;
        tick();
        flush_b = 3'b000;
        checkOutput("b_flush_v2", 128'(valid_out_b[2]), 128'h0);
        checkOutput("b_flush_d2", 128'(data_out_b[47:32]), 128'h1234);
        checkOutput("b_flush_fcnt", 128'(flush_cnt_b), 128'h1);
        stall_b = 3'b010;
        for (int i = 1; i <= 4; i++) begin
            tick();
            checkOutput("b_sat_bcnt", 128'(bubble_cnt_b), (i >= 3) ? 128'h3 : 128'(i));
        end
        checkOutput("b_bub_d2", 128'(data_out_b[47:32]), 128'h1234);
        checkOutput("b_bub_v2", 128'(valid_out_b[2]), 128'h0);
        rst_n_b = 1'b0;
        tick();
        checkOutput("b_mrst_bcnt", 128'(bubble_cnt_b), 128'h0);
        checkOutput("b_mrst_data", 128'(data_out_b), 128'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
